// File: rtl/pla.sv
// Registered programmable logic array: a programmable AND plane feeding a programmable OR plane.
// Optional macro PLA_INPUT_REG_EN adds a register on the input vector, giving 2-cycle latency from in.
module pla #(
  parameter int IN_WIDTH  = 4,
  parameter int OUT_WIDTH = 4,
  parameter int AND_WIDTH = 4
) (
  input  logic [IN_WIDTH-1:0]    in,
  output logic [OUT_WIDTH-1:0]   out,
  input  logic [2*IN_WIDTH-1:0]  andSel [AND_WIDTH],
  input  logic [AND_WIDTH-1:0]   orSel  [OUT_WIDTH],
  input  logic                   clk,
  input  logic                   rst
);

  logic [IN_WIDTH-1:0]  w_in;
  logic [AND_WIDTH-1:0] w_prod;
  logic [OUT_WIDTH-1:0] w_sum;
  logic [OUT_WIDTH-1:0] r_out;

  // Unselected literals are forced true; a term with no literals at all is forced false.
  function automatic logic product_term(input logic [2*IN_WIDTH-1:0] sel,
                                        input logic [IN_WIDTH-1:0]   vec);
    logic [2*IN_WIDTH-1:0] lit;
    lit = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      lit[2*i]   = vec[i];
      lit[2*i+1] = ~vec[i];
    end
    return (|sel) & (&(lit | ~sel));
  endfunction

`ifdef PLA_INPUT_REG_EN
  logic [IN_WIDTH-1:0] r_in;

  // Input capture register, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in <= '0;
    end else begin
      r_in <= in;
    end
  end

  assign w_in = r_in;
`else
  assign w_in = in;
`endif

  // AND plane: one product term per andSel entry.
  always_comb begin
    w_prod = '0;
    for (int j = 0; j < AND_WIDTH; j++) begin
      w_prod[j] = product_term(andSel[j], w_in);
    end
  end

  // OR plane: each output sums the product terms its orSel entry selects.
  always_comb begin
    w_sum = '0;
    for (int k = 0; k < OUT_WIDTH; k++) begin
      w_sum[k] = |(w_prod & orSel[k]);
    end
  end

  // Output register; reset discards whatever result was pending.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out <= '0;
    end else begin
      r_out <= w_sum;
    end
  end

  assign out = r_out;

endmodule

// File: tb/tb_pla.sv
// Self-checking bench for pla: directed steps plus randomized programming/inputs against a sum-of-products model.
// Expected latency follows PLA_INPUT_REG_EN when the bench is built with that macro.
module tb_pla;
  localparam int IW = 4;
  localparam int OW = 4;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [IW-1:0]     in_s;
  logic [OW-1:0]     out_s;
  logic [2*IW-1:0]   and_sel [AW];
  logic [AW-1:0]     or_sel  [OW];

  int checks   = 0;
  int failures = 0;
  logic [IW-1:0] m_in_reg = '0;

  pla #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .AND_WIDTH(AW)) dut (
    .in(in_s), .out(out_s), .andSel(and_sel), .orSel(or_sel), .clk(clk), .rst(rst)
  );

  always #5 clk = ~clk;

  function automatic bit term_value(input int j, input logic [IW-1:0] x);
    bit t;
    if (and_sel[j] == '0) return 1'b0;
    t = 1'b1;
    for (int i = 0; i < IW; i++) begin
      if (and_sel[j][2*i] && !x[i]) t = 1'b0;
      if (and_sel[j][2*i+1] && x[i]) t = 1'b0;
    end
    return t;
  endfunction

  function automatic logic [OW-1:0] ref_pla(input logic [IW-1:0] x);
    logic [OW-1:0] r;
    r = '0;
    for (int k = 0; k < OW; k++)
      for (int j = 0; j < AW; j++)
        if (or_sel[k][j] && term_value(j, x)) r[k] = 1'b1;
    return r;
  endfunction

  task automatic tick(input string tag, input bit use_const, input logic [OW-1:0] want);
    logic [OW-1:0] exp;
`ifdef PLA_INPUT_REG_EN
    exp      = rst ? '0 : ref_pla(m_in_reg);
    m_in_reg = rst ? '0 : in_s;
`else
    exp = rst ? '0 : ref_pla(in_s);
`endif
    @(posedge clk);
    #1;
    checks++;
    assert (out_s === exp) else begin
      failures++;
      $error("FAIL %s: out=%b expected=%b", tag, out_s, exp);
    end
    if (use_const) begin
      checks++;
      assert (out_s === want) else begin
        failures++;
        $error("FAIL %s_const: out=%b expected=%b", tag, out_s, want);
      end
    end
  endtask

  task automatic load_default();
    for (int j = 0; j < AW; j++) and_sel[j] = 8'(j + 1);
    for (int k = 0; k < OW; k++) or_sel[k] = 4'(k + 1);
  endtask

  initial begin
    load_default();
    rst  = 1'b1;
    in_s = 4'hF;
    @(posedge clk); #1;
    tick("reset", 1'b1, 4'b0000);

    rst  = 1'b0;
    in_s = 4'b0000;
    tick("in0_a", 1'b0, 4'b0000);
    tick("in0", 1'b1, 4'b0110);
    in_s = 4'b0001;
    tick("in1_a", 1'b0, 4'b0000);
    tick("in1", 1'b1, 4'b0101);
    in_s = 4'b0011;
    tick("in3_a", 1'b0, 4'b0000);
    tick("in3", 1'b1, 4'b0101);

    // Empty product term and empty OR selection
    and_sel[3] = 8'h00;
    or_sel[3]  = 4'b1000;
    or_sel[0]  = 4'b0000;
    for (int n = 0; n < 6; n++) begin
      in_s = 4'($urandom);
      tick("empty_a", 1'b0, 4'b0000);
      tick("empty", 1'b0, 4'b0000);
      checks++;
      assert (out_s[3] === 1'b0 && out_s[0] === 1'b0) else begin
        failures++;
        $error("FAIL empty_bits: out=%b expected=0xx0", out_s);
      end
    end

    // Toggle every cycle
    load_default();
    for (int n = 0; n < 20; n++) begin
      in_s = (n % 2 == 0) ? 4'b0000 : 4'b0001;
      tick("toggle", 1'b0, 4'b0000);
    end

    // Reset mid-operation
    in_s = 4'b0101;
    tick("pre_rst", 1'b0, 4'b0000);
    in_s = 4'b1010;
    rst  = 1'b1;
    tick("rst_mid", 1'b1, 4'b0000);
    rst  = 1'b0;
    in_s = 4'b0000;
    tick("rst_rel", 1'b1, 4'b0110);
    tick("rst_rel2", 1'b1, 4'b0110);

    // Randomized programming and inputs, changing every cycle, occasional reset
    for (int n = 0; n < 300; n++) begin
      in_s = 4'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < AW; j++) and_sel[j] = 8'($urandom) & 8'($urandom);
        for (int k = 0; k < OW; k++) or_sel[k] = 4'($urandom);
      end
      rst = ($urandom_range(0, 15) == 0);
      tick("random", 1'b0, 4'b0000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
